fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline definitions: fetch control state encoding, defaults and the
// bubble instruction injected by fetch.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2,
    StHalt  = 2'd3
  } ctrl_state_e;

  localparam int unsigned FlushCyclesDefault = 1;
  localparam int unsigned CntWDefault        = 16;

  // addi x0, x0, 0
  localparam logic [31:0] NopInsn = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: redirects on mispredict, inserts bubbles for hazards and
// flush windows, halts on ecall/ebreak, and counts redirects and stall cycles.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault,
  parameter int unsigned CNT_W        = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             ex_branch_valid,
  input  logic             ex_branch_miss,
  input  logic [31:0]      ex_branch_target,
  input  logic             load_use_hazard,
  input  logic             imem_ready,
  output logic             nop,
  output logic             branch_miss_contral,
  output logic [31:0]      branch_miss_PC,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Counter holds the number of FLUSH cycles left after the current one.
  localparam logic [1:0] FlushLoad = (FLUSH_CYCLES > 0) ? 2'(FLUSH_CYCLES - 1) : 2'd0;

  ctrl_state_e state_q;
  logic [1:0]  flush_cnt_q;
  logic        redirect;
  logic        hazard;
  logic        stall_inc;

  assign redirect = ex_branch_valid & ex_branch_miss & (state_q != StHalt) & ~halt_req;
  assign hazard   = load_use_hazard | ~imem_ready;

  always_comb begin
    branch_miss_contral = redirect;
    branch_miss_PC      = redirect ? ex_branch_target : 32'd0;
    flush_idex          = redirect;
    flush_ifid          = redirect | (state_q == StFlush);
    nop                 = redirect | (state_q == StFlush) | (state_q == StHalt) |
                          halt_req | hazard;
    ctrl_state          = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StRun;
      flush_cnt_q <= 2'd0;
    end else if (halt_req || (state_q == StHalt)) begin
      state_q <= StHalt;
    end else if (redirect) begin
      if (FLUSH_CYCLES > 0) begin
        state_q     <= StFlush;
        flush_cnt_q <= FlushLoad;
      end else begin
        state_q <= StRun;
      end
    end else if ((state_q == StFlush) && (flush_cnt_q != 2'd0)) begin
      flush_cnt_q <= flush_cnt_q - 2'd1;
    end else begin
      state_q <= hazard ? StStall : StRun;
    end
  end

  assign stall_inc = nop & (state_q != StHalt);

  sat_counter #(
    .Width(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (redirect),
    .count(redirect_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

endmodule
